// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states and
// the operation/response register layouts.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;

    // Opcodes above this value are illegal.
    localparam logic [4:0] OP_LAST_LEGAL = OP_SRA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]        opcode;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              id;
    } op_t;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] result;
        logic              ne;
        logic              lt;
        logic              ovf;
        logic              illegal;
    } rsp_t;

    function automatic logic is_legal(input logic [4:0] opcode);
        return (opcode <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
interface alu_arbiter_if;
    import alu_pkg::*;

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid and payload stay stable until then, and ready never waits on
    // anything but the state of the receiver and the presented valids.
    logic              req0_valid;
    logic              req0_ready;
    logic [4:0]        req0_opcode;
    logic [4:0]        req0_shamt;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [4:0]        req1_opcode;
    logic [4:0]        req1_shamt;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_ne;
    logic              rsp_lt;
    logic              rsp_ovf;
    logic              rsp_illegal;

    modport slave (
        input  req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf, rsp_illegal
    );

    modport master (
        output req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf, rsp_illegal
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both request ports.
module alu
    import alu_pkg::*;
(
    input  logic [4:0]        opcode,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] data_result,
    output logic              is_not_equal,
    output logic              is_less_than,
    output logic              overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        data_result = '0;
        overflow    = 1'b0;
        case (opcode)
            OP_ADD: begin
                data_result = sum;
                // Signed overflow: same-sign operands giving a different-sign sum.
                overflow    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                data_result = diff;
                overflow    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  data_result = a & b;
            OP_OR:   data_result = a | b;
            OP_SLL:  data_result = a << shamt;
            OP_SRA:  data_result = $signed(a) >>> shamt;
            default: data_result = '0;
        endcase
    end

    assign is_not_equal = (a != b);
    assign is_less_than = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end to a single shared ALU: arbitrates, latches one operation,
// executes it for one cycle and holds the response until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
)
(
    input  logic          clock,
    input  logic          reset_n,
    alu_arbiter_if.slave  bus,
    output state_t        dbg_state
);

    state_t state;
    state_t state_nxt;

    // 1 = port 1 was granted most recently, so port 0 wins the next tie.
    logic last_grant;

    op_t  op_q;
    op_t  op_in;
    rsp_t rsp_q;
    rsp_t rsp_nxt;

    logic grant0;
    logic grant1;
    logic accept;
    logic take;
    logic op_legal;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ne;
    logic              alu_lt;
    logic              alu_ovf;

    // Arbitration
    always_comb begin
        grant0 = 1'b0;
        if (RR_EN != 0) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        end else begin
            grant0 = bus.req0_valid;
        end
        grant1 = bus.req1_valid && !grant0;
    end

    assign accept = (state == ST_IDLE) || ((state == ST_DONE) && bus.rsp_ready);
    assign take   = accept && (grant0 || grant1);

    assign bus.req0_ready = reset_n && accept && grant0;
    assign bus.req1_ready = reset_n && accept && grant1;

    always_comb begin
        op_in = '{opcode: bus.req0_opcode, shamt: bus.req0_shamt,
                  a: bus.req0_a, b: bus.req0_b, id: 1'b0};
        if (grant1) begin
            op_in = '{opcode: bus.req1_opcode, shamt: bus.req1_shamt,
                      a: bus.req1_a, b: bus.req1_b, id: 1'b1};
        end
    end

    // FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_nxt = take ? ST_EXEC : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= '0;
            last_grant <= 1'b1;
        end else if (take) begin
            op_q       <= op_in;
            last_grant <= grant1;
        end
    end

    // Shared ALU sees only the latched operation, never the request inputs.
    alu u_alu (
        .opcode       (op_q.opcode),
        .shamt        (op_q.shamt),
        .a            (op_q.a),
        .b            (op_q.b),
        .data_result  (alu_result),
        .is_not_equal (alu_ne),
        .is_less_than (alu_lt),
        .overflow     (alu_ovf)
    );

    always_comb begin
        op_legal        = is_legal(op_q.opcode);
        rsp_nxt         = '0;
        rsp_nxt.id      = op_q.id;
        rsp_nxt.illegal = !op_legal;
        if (op_legal) begin
            rsp_nxt.result = alu_result;
            if (op_q.opcode == OP_SUB) begin
                rsp_nxt.ne = alu_ne;
                rsp_nxt.lt = alu_lt;
            end
            if ((op_q.opcode == OP_ADD) || (op_q.opcode == OP_SUB)) begin
                rsp_nxt.ovf = alu_ovf;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q <= '0;
        end else if (state == ST_EXEC) begin
            rsp_q <= rsp_nxt;
        end
    end

    assign bus.rsp_valid   = (state == ST_DONE);
    assign bus.rsp_id      = rsp_q.id;
    assign bus.rsp_result  = rsp_q.result;
    assign bus.rsp_ne      = rsp_q.ne;
    assign bus.rsp_lt      = rsp_q.lt;
    assign bus.rsp_ovf     = rsp_q.ovf;
    assign bus.rsp_illegal = rsp_q.illegal;

    assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [4:0]  opcode;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic        ill;
    } vec_t;

    localparam int NV = 15;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    alu_arbiter_if bus_rr();
    alu_arbiter_if bus_fp();
    state_t state_rr;
    state_t state_fp;

    alu_arbiter #(.RR_EN(1)) dut_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_rr),
        .dbg_state (state_rr)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_fp),
        .dbg_state (state_fp)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_rr.req0_valid = 0; bus_rr.req0_opcode = 0; bus_rr.req0_shamt = 0;
        bus_rr.req0_a = 0; bus_rr.req0_b = 0;
        bus_rr.req1_valid = 0; bus_rr.req1_opcode = 0; bus_rr.req1_shamt = 0;
        bus_rr.req1_a = 0; bus_rr.req1_b = 0;
        bus_rr.rsp_ready = 1;
        bus_fp.req0_valid = 0; bus_fp.req0_opcode = 0; bus_fp.req0_shamt = 0;
        bus_fp.req0_a = 0; bus_fp.req0_b = 0;
        bus_fp.req1_valid = 0; bus_fp.req1_opcode = 0; bus_fp.req1_shamt = 0;
        bus_fp.req1_a = 0; bus_fp.req1_b = 0;
        bus_fp.rsp_ready = 1;
    endtask

    task automatic drive_rr(input int port, input logic [4:0] opc, input logic [4:0] sh,
                            input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            bus_rr.req0_opcode = opc; bus_rr.req0_shamt = sh;
            bus_rr.req0_a = a; bus_rr.req0_b = b; bus_rr.req0_valid = 1;
        end else begin
            bus_rr.req1_opcode = opc; bus_rr.req1_shamt = sh;
            bus_rr.req1_a = a; bus_rr.req1_b = b; bus_rr.req1_valid = 1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic wait_accept_rr(input int port, input string name);
        logic rdy;
        logic got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            rdy = (port == 0) ? bus_rr.req0_ready : bus_rr.req1_ready;
            @(posedge clock);
            if (rdy) got = 1;
            @(negedge clock);
        end
        chk({name, "_accept"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int onehot_err;
        int p1_hits;
        logic [31:0] e;

        vecs[0]  = '{OP_ADD, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0};
        vecs[1]  = '{OP_SUB, 5'd0,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, 1, 0, 0};
        vecs[2]  = '{OP_SUB, 5'd0,  32'h00000003, 32'h00000003, 32'h00000000, 0, 0, 0, 0};
        vecs[3]  = '{OP_SUB, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 1, 0};
        vecs[4]  = '{OP_AND, 5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0};
        vecs[5]  = '{OP_OR,  5'd0,  32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0};
        vecs[6]  = '{OP_SLL, 5'd31, 32'h00000001, 32'h00000009, 32'h80000000, 0, 0, 0, 0};
        vecs[7]  = '{OP_SLL, 5'd4,  32'h0000000F, 32'h00000000, 32'h000000F0, 0, 0, 0, 0};
        vecs[8]  = '{OP_SRA, 5'd31, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0};
        vecs[9]  = '{OP_SRA, 5'd4,  32'h7FFFFFFF, 32'h00000000, 32'h07FFFFFF, 0, 0, 0, 0};
        vecs[10] = '{5'b00111, 5'd0, 32'h00000003, 32'h00000004, 32'h00000000, 0, 0, 0, 1};
        vecs[11] = '{5'b11111, 5'd3, 32'h80000000, 32'h00000001, 32'h00000000, 0, 0, 0, 1};
        vecs[12] = '{OP_ADD, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0, 0};
        vecs[13] = '{OP_SUB, 5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1, 0};
        vecs[14] = '{OP_SRA, 5'd0,  32'h80000001, 32'h00000000, 32'h80000001, 0, 0, 0, 0};

        // Reset state
        clear_inputs();
        reset_n = 0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_rr_state", state_rr, ST_IDLE);
        chk("rst_fp_state", state_fp, ST_IDLE);
        chk("rst_rsp_valid", bus_rr.rsp_valid, 0);
        chk("rst_rsp_result", bus_rr.rsp_result, 0);
        chk("rst_rsp_flags", {bus_rr.rsp_id, bus_rr.rsp_ne, bus_rr.rsp_lt,
                              bus_rr.rsp_ovf, bus_rr.rsp_illegal}, 0);
        chk("rst_readys", {bus_rr.req0_ready, bus_rr.req1_ready}, 0);
        @(negedge clock);
        reset_n = 1;

        // Table of single operations on port 0
        for (int i = 0; i < NV; i++) begin
            drive_rr(0, vecs[i].opcode, vecs[i].shamt, vecs[i].a, vecs[i].b);
            wait_accept_rr(0, $sformatf("vec%0d", i));
            bus_rr.req0_valid = 0;
            exp_q.push_back(vecs[i].result);
            #1;
            chk($sformatf("vec%0d_exec_valid", i), bus_rr.rsp_valid, 0);
            @(negedge clock);
            #1;
            chk($sformatf("vec%0d_valid", i), bus_rr.rsp_valid, 1);
            chk($sformatf("vec%0d_result", i), bus_rr.rsp_result, exp_q.pop_front());
            chk($sformatf("vec%0d_flags", i),
                {bus_rr.rsp_id, bus_rr.rsp_ne, bus_rr.rsp_lt, bus_rr.rsp_ovf, bus_rr.rsp_illegal},
                {1'b0, vecs[i].ne, vecs[i].lt, vecs[i].ovf, vecs[i].ill});
            @(negedge clock);
        end

        // Round-robin alternation with both ports continuously valid
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        drive_rr(0, OP_ADD, 5'd0, 32'd1, 32'd2);
        drive_rr(1, OP_SUB, 5'd0, 32'd5, 32'd7);
        exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
        n = 0;
        onehot_err = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            #1;
            if (bus_rr.req0_ready && bus_rr.req1_ready) onehot_err++;
            if (bus_rr.rsp_valid) begin
                e = exp_q.pop_front();
                chk($sformatf("rr_id%0d", n), bus_rr.rsp_id, e);
                if (e == 1) begin
                    chk($sformatf("rr_sub_result%0d", n), bus_rr.rsp_result, 32'hFFFFFFFE);
                    chk($sformatf("rr_sub_flags%0d", n),
                        {bus_rr.rsp_ne, bus_rr.rsp_lt, bus_rr.rsp_ovf}, 3'b110);
                end else begin
                    chk($sformatf("rr_add_result%0d", n), bus_rr.rsp_result, 32'd3);
                end
                n++;
            end
            @(negedge clock);
        end
        chk("rr_count", n, 4);
        chk("rr_onehot", onehot_err, 0);
        bus_rr.req0_valid = 0;
        bus_rr.req1_valid = 0;
        repeat (4) @(negedge clock);
        #1;
        chk("rr_drain_idle", state_rr, ST_IDLE);
        @(negedge clock);

        // Consumer back-pressure in DONE with a pending request on port 1
        bus_rr.rsp_ready = 0;
        drive_rr(0, OP_ADD, 5'd0, 32'd10, 32'd20);
        wait_accept_rr(0, "stall");
        bus_rr.req0_valid = 0;
        @(negedge clock);
        drive_rr(1, OP_SUB, 5'd0, 32'd9, 32'd4);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_valid", k), bus_rr.rsp_valid, 1);
            chk($sformatf("stall%0d_result", k), bus_rr.rsp_result, 32'd30);
            chk($sformatf("stall%0d_readys", k), {bus_rr.req0_ready, bus_rr.req1_ready}, 0);
            @(negedge clock);
        end
        bus_rr.rsp_ready = 1;
        #1;
        chk("stall_release_ready1", bus_rr.req1_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus_rr.req1_valid = 0;
        #1;
        chk("stall_exec_valid", bus_rr.rsp_valid, 0);
        @(negedge clock);
        #1;
        chk("stall_rsp_valid", bus_rr.rsp_valid, 1);
        chk("stall_rsp_result", bus_rr.rsp_result, 32'd5);
        chk("stall_rsp_id", bus_rr.rsp_id, 1);
        @(negedge clock);

        // Reset pulse while an operation is in EXEC
        drive_rr(0, OP_ADD, 5'd0, 32'd100, 32'd1);
        wait_accept_rr(0, "rst_exec");
        bus_rr.req0_valid = 0;
        #1;
        chk("rst_exec_state", state_rr, ST_EXEC);
        reset_n = 0;
        drive_rr(0, OP_OR, 5'd0, 32'h000000F0, 32'h0000000F);
        drive_rr(1, OP_AND, 5'd0, 32'hFFFFFFFF, 32'h0000000F);
        #1;
        chk("rst_exec_valid", bus_rr.rsp_valid, 0);
        chk("rst_exec_result", bus_rr.rsp_result, 0);
        chk("rst_exec_idle", state_rr, ST_IDLE);
        chk("rst_exec_readys", {bus_rr.req0_ready, bus_rr.req1_ready}, 0);
        @(negedge clock);
        reset_n = 1;
        #1;
        chk("post_rst_grant", {bus_rr.req0_ready, bus_rr.req1_ready}, 2'b10);
        chk("post_rst_valid", bus_rr.rsp_valid, 0);
        @(posedge clock);
        @(negedge clock);
        bus_rr.req0_valid = 0;
        bus_rr.req1_valid = 0;
        #1;
        chk("post_rst_exec_valid", bus_rr.rsp_valid, 0);
        @(negedge clock);
        #1;
        chk("post_rst_rsp_valid", bus_rr.rsp_valid, 1);
        chk("post_rst_rsp_id", bus_rr.rsp_id, 0);
        chk("post_rst_rsp_result", bus_rr.rsp_result, 32'h000000FF);
        @(negedge clock);

        // Fixed priority: port 0 always wins, port 1 starves
        bus_fp.req0_opcode = OP_ADD; bus_fp.req0_a = 32'd2; bus_fp.req0_b = 32'd3;
        bus_fp.req1_opcode = OP_SUB; bus_fp.req1_a = 32'd8; bus_fp.req1_b = 32'd1;
        bus_fp.req0_valid = 1;
        bus_fp.req1_valid = 1;
        n = 0;
        p1_hits = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            #1;
            if (bus_fp.req1_ready) p1_hits++;
            if (bus_fp.rsp_valid) begin
                chk($sformatf("fp_id%0d", n), bus_fp.rsp_id, 0);
                chk($sformatf("fp_result%0d", n), bus_fp.rsp_result, 32'd5);
                n++;
            end
            @(negedge clock);
        end
        chk("fp_count", n, 4);
        chk("fp_port1_stalled", p1_hits, 0);
        bus_fp.req0_valid = 0;
        bus_fp.req1_valid = 0;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
